// File: rtl/mips16_pkg.sv
// Shared definitions for the mips16 retire-trace unit.
// Opcode/funct values recognised by the classifier, trace class encodings,
// FSM states and the default trace entry width {class, pc, instr}.
package mips16_pkg;

    localparam int INSTR_W = 32;
    localparam int CLS_W   = 3;
    localparam int TRACE_W = CLS_W + 32 + INSTR_W;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SHL   = 6'h06;
    localparam logic [5:0] OP_SHR   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LI    = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (instr[9:4] in this core)
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h23;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h30;

    typedef enum logic [2:0] {
        CLS_RTYPE  = 3'd0,
        CLS_IMMALU = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_SHIFT  = 3'd5,
        CLS_LI     = 3'd6,
        CLS_JUMP   = 3'd7
    } trace_class_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic         known;
        trace_class_e cls;
    } decode_t;

endpackage

// File: rtl/mips16_trace_unit_if.sv
// Retire/trace bus of the mips16 trace unit.
//   master: core + trace consumer side (drives retire_* and trace_ready)
//   slave : trace unit (drives trace_valid / trace_data)
interface mips16_trace_unit_if #(
    parameter int PC_W = 32
);
    logic                   retire_valid;
    logic [PC_W-1:0]        retire_pc;
    logic [31:0]            retire_instr;
    logic                   trace_ready;
    logic                   trace_valid;
    logic [3+PC_W+32-1:0]   trace_data;

    modport master (
        output retire_valid, retire_pc, retire_instr, trace_ready,
        input  trace_valid, trace_data
    );

    modport slave (
        input  retire_valid, retire_pc, retire_instr, trace_ready,
        output trace_valid, trace_data
    );
endinterface

// File: rtl/mips16_trace_fifo.sv
// Show-ahead trace FIFO, DEPTH x WIDTH.
// Ports: clock, reset (sync, active-high), push/wdata, pop (ignored when empty),
//        rdata (head entry), empty, count, drop (pulse: a push lost an entry).
// When full and pushed without a simultaneous pop, OVERWRITE=0 drops the new
// entry and OVERWRITE=1 discards the oldest one instead.
module mips16_trace_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 67,
    parameter bit OVERWRITE = 1'b0,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             pop_ok_s;
    logic             wr_en_s;
    logic             rd_adv_s;
    logic             drop_s;

    // Resolve push/pop into write, read-advance and drop for this cycle
    always_comb begin
        full_s   = (count_r == CW'(DEPTH));
        pop_ok_s = pop && (count_r != '0);
        wr_en_s  = 1'b0;
        rd_adv_s = pop_ok_s;
        drop_s   = 1'b0;
        if (push) begin
            if (full_s && !pop_ok_s) begin
                drop_s = 1'b1;
                if (OVERWRITE) begin
                    wr_en_s  = 1'b1;
                    rd_adv_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end else begin
                wr_en_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers (wrap mod DEPTH through their width) and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (rd_adv_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({wr_en_s, rd_adv_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = (count_r == '0);
    assign count = count_r;
    assign drop  = drop_s;

endmodule

// File: rtl/mips16_trace_unit.sv
// Retire-trace and halt monitor for the mips16 core.
// Ports: clock, reset (sync, active-high), bus (retire in / trace out, slave),
//        class_counts (8 saturating counters, class k at [k*CNT_W +: CNT_W]),
//        cycle_count (RUN cycles), drop_count (lost entries), illegal (sticky),
//        halted (sticky), done (halted and drained).
module mips16_trace_unit
    import mips16_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              DEPTH     = 16,
    parameter int              CNT_W     = 16,
    parameter logic [PC_W-1:0] HALT_PC   = PC_W'(32'hffff),
    parameter bit              OVERWRITE = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    mips16_trace_unit_if.slave   bus,
    output logic [8*CNT_W-1:0]   class_counts,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 illegal,
    output logic                 halted,
    output logic                 done
);

    localparam int TW = CLS_W + PC_W + INSTR_W;
    localparam int CW = $clog2(DEPTH) + 1;

    function automatic decode_t decode(input logic [31:0] instr);
        decode_t d;
        d.known = 1'b1;
        d.cls   = CLS_RTYPE;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[9:4])
                    FN_ADD, FN_ADDU, FN_SUB, FN_OR, FN_SLT: d.cls = CLS_RTYPE;
                    default:                                d.known = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: d.cls = CLS_IMMALU;
            OP_LW:                             d.cls = CLS_LOAD;
            OP_SW:                             d.cls = CLS_STORE;
            OP_BEQ, OP_BNE:                    d.cls = CLS_BRANCH;
            OP_SHL, OP_SHR:                    d.cls = CLS_SHIFT;
            OP_LI:                             d.cls = CLS_LI;
            OP_J, OP_JAL:                      d.cls = CLS_JUMP;
            default:                           d.known = 1'b0;
        endcase
        // Unknown encodings are traced as class 0
        if (!d.known) d.cls = CLS_RTYPE;
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        else    return v + CNT_W'(1);
    endfunction

    trace_state_e     state_r;
    logic [CNT_W-1:0] cls_cnt_r [8];
    logic [CNT_W-1:0] cycle_r;
    logic [CNT_W-1:0] drop_r;
    logic             illegal_r;
    logic             halted_r;
    logic             done_r;

    decode_t          decode_s;
    logic             is_halt_s;
    logic             push_s;
    logic [TW-1:0]    entry_s;
    logic             fifo_empty_s;
    logic             fifo_drop_s;
    logic [CW-1:0]    fifo_count_s;

    // Classify the retiring instruction and form the trace entry
    always_comb begin
        decode_s  = decode(bus.retire_instr);
        is_halt_s = (bus.retire_pc == HALT_PC);
        entry_s   = {decode_s.cls, bus.retire_pc, bus.retire_instr};
        if ((state_r == ST_RUN) && bus.retire_valid && !is_halt_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    mips16_trace_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (TW),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .wdata (entry_s),
        .pop   (bus.trace_ready),
        .rdata (bus.trace_data),
        .empty (fifo_empty_s),
        .count (fifo_count_s),
        .drop  (fifo_drop_s)
    );

    // RUN/DRAIN/DONE sequencing with its counters and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_RUN;
            cycle_r   <= '0;
            drop_r    <= '0;
            illegal_r <= 1'b0;
            halted_r  <= 1'b0;
            done_r    <= 1'b0;
            for (int k = 0; k < 8; k++) cls_cnt_r[k] <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // The halt cycle itself still counts as a RUN cycle
                    cycle_r <= sat_inc(cycle_r);
                    if (bus.retire_valid) begin
                        if (is_halt_s) begin
                            halted_r <= 1'b1;
                            state_r  <= ST_DRAIN;
                        end else if (decode_s.known) begin
                            cls_cnt_r[decode_s.cls] <= sat_inc(cls_cnt_r[decode_s.cls]);
                        end else begin
                            illegal_r <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
            if (fifo_drop_s) drop_r <= sat_inc(drop_r);
        end
    end

    // Flatten the per-class counters onto the output bus
    always_comb begin
        class_counts = '0;
        for (int k = 0; k < 8; k++) class_counts[k*CNT_W +: CNT_W] = cls_cnt_r[k];
    end

    assign bus.trace_valid = (fifo_count_s != '0);
    assign cycle_count     = cycle_r;
    assign drop_count      = drop_r;
    assign illegal         = illegal_r;
    assign halted          = halted_r;
    assign done            = done_r;

endmodule

// File: tb/tb_mips16_trace_unit.sv
module tb_mips16_trace_unit;

    localparam int ND = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rv    = 1'b0;
    logic [31:0] pc    = 32'h0;
    logic [31:0] instr = 32'h0;
    logic        rdy   = 1'b0;

    always #5 clock = ~clock;

    mips16_trace_unit_if #(.PC_W(32)) if0 ();
    mips16_trace_unit_if #(.PC_W(32)) if1 ();
    mips16_trace_unit_if #(.PC_W(32)) if2 ();

    assign if0.retire_valid = rv;  assign if1.retire_valid = rv;  assign if2.retire_valid = rv;
    assign if0.retire_pc    = pc;  assign if1.retire_pc    = pc;  assign if2.retire_pc    = pc;
    assign if0.retire_instr = instr; assign if1.retire_instr = instr; assign if2.retire_instr = instr;
    assign if0.trace_ready  = rdy; assign if1.trace_ready  = rdy; assign if2.trace_ready  = rdy;

    logic [127:0] cc0;
    logic [31:0]  cc1, cc2;
    logic [15:0]  cyc0, drp0;
    logic [3:0]   cyc1, drp1, cyc2, drp2;
    logic [2:0]   ill, hlt, dn;

    mips16_trace_unit u_dut0 (
        .clock(clock), .reset(reset), .bus(if0.slave), .class_counts(cc0),
        .cycle_count(cyc0), .drop_count(drp0), .illegal(ill[0]), .halted(hlt[0]), .done(dn[0]));
    mips16_trace_unit #(.DEPTH(4), .CNT_W(4), .OVERWRITE(1'b0)) u_dut1 (
        .clock(clock), .reset(reset), .bus(if1.slave), .class_counts(cc1),
        .cycle_count(cyc1), .drop_count(drp1), .illegal(ill[1]), .halted(hlt[1]), .done(dn[1]));
    mips16_trace_unit #(.DEPTH(4), .CNT_W(4), .OVERWRITE(1'b1)) u_dut2 (
        .clock(clock), .reset(reset), .bus(if2.slave), .class_counts(cc2),
        .cycle_count(cyc2), .drop_count(drp2), .illegal(ill[2]), .halted(hlt[2]), .done(dn[2]));

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model (queues + plain arithmetic) ----------------
    int          m_depth [ND] = '{16, 4, 4};
    bit          m_ow    [ND] = '{1'b0, 1'b0, 1'b1};
    int          m_max   [ND] = '{65535, 15, 15};
    logic [66:0] mq      [ND][$];
    int          m_cls   [ND][8];
    int          m_cyc   [ND];
    int          m_drop  [ND];
    bit          m_ill   [ND];
    bit          m_halt  [ND];
    int          m_phase [ND];   // 0 running, 1 draining, 2 finished

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 16'hA5C3, fn, 4'h9};
    endfunction

    function automatic void ref_class(input logic [31:0] i, output int cls, output bit known);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[9:4];
        known = 1'b1;
        cls = 0;
        if (op == 6'h00) known = fn inside {6'h20, 6'h21, 6'h23, 6'h25, 6'h30};
        else if (op inside {6'h08, 6'h0a, 6'h0c, 6'h0d}) cls = 1;
        else if (op == 6'h23) cls = 2;
        else if (op == 6'h2b) cls = 3;
        else if (op inside {6'h04, 6'h05}) cls = 4;
        else if (op inside {6'h06, 6'h07}) cls = 5;
        else if (op == 6'h0f) cls = 6;
        else if (op inside {6'h02, 6'h03}) cls = 7;
        else known = 1'b0;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            if (reset) begin
                mq[d].delete();
                for (int k = 0; k < 8; k++) m_cls[d][k] = 0;
                m_cyc[d] = 0; m_drop[d] = 0; m_ill[d] = 1'b0; m_halt[d] = 1'b0; m_phase[d] = 0;
            end else begin
                bit          do_pop;
                bit          do_push;
                logic [66:0] e;
                int          cls;
                bit          known;
                do_pop  = rdy && (mq[d].size() > 0);
                do_push = 1'b0;
                e = '0;
                if (m_phase[d] == 0) begin
                    m_cyc[d] = sat(m_cyc[d] + 1, m_max[d]);
                    if (rv) begin
                        if (pc == 32'hffff) begin
                            m_halt[d] = 1'b1;
                            m_phase[d] = 1;
                        end else begin
                            ref_class(instr, cls, known);
                            if (known) m_cls[d][cls] = sat(m_cls[d][cls] + 1, m_max[d]);
                            else m_ill[d] = 1'b1;
                            do_push = 1'b1;
                            e = {3'(cls), pc, instr};
                        end
                    end
                end else if (m_phase[d] == 1 && mq[d].size() == 0) begin
                    m_phase[d] = 2;
                end
                if (do_pop) void'(mq[d].pop_front());
                if (do_push) begin
                    if (mq[d].size() < m_depth[d]) begin
                        mq[d].push_back(e);
                    end else begin
                        m_drop[d] = sat(m_drop[d] + 1, m_max[d]);
                        if (m_ow[d]) begin
                            void'(mq[d].pop_front());
                            mq[d].push_back(e);
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int get_cc(input int d, input int k);
        case (d)
            0:       return int'(cc0[k*16 +: 16]);
            1:       return int'(cc1[k*4 +: 4]);
            default: return int'(cc2[k*4 +: 4]);
        endcase
    endfunction

    task automatic check_model();
        for (int d = 0; d < ND; d++) begin
            logic        tv;
            logic [66:0] td;
            int          cy;
            int          dr;
            case (d)
                0:       begin tv = if0.trace_valid; td = if0.trace_data; cy = int'(cyc0); dr = int'(drp0); end
                1:       begin tv = if1.trace_valid; td = if1.trace_data; cy = int'(cyc1); dr = int'(drp1); end
                default: begin tv = if2.trace_valid; td = if2.trace_data; cy = int'(cyc2); dr = int'(drp2); end
            endcase
            chk($sformatf("d%0d trace_valid", d), 128'(tv), 128'(mq[d].size() > 0));
            if (mq[d].size() > 0) chk($sformatf("d%0d trace_data", d), 128'(td), 128'(mq[d][0]));
            for (int k = 0; k < 8; k++)
                chk($sformatf("d%0d class_count[%0d]", d, k), 128'(get_cc(d, k)), 128'(m_cls[d][k]));
            chk($sformatf("d%0d cycle_count", d), 128'(cy), 128'(m_cyc[d]));
            chk($sformatf("d%0d drop_count", d), 128'(dr), 128'(m_drop[d]));
            chk($sformatf("d%0d illegal", d), 128'(ill[d]), 128'(m_ill[d]));
            chk($sformatf("d%0d halted", d), 128'(hlt[d]), 128'(m_halt[d]));
            chk($sformatf("d%0d done", d), 128'(dn[d]), 128'(m_phase[d] == 2));
        end
    endtask

    // One clock: apply inputs, advance the model, compare after the edge
    task automatic step(input bit r, input bit v, input logic [31:0] p, input logic [31:0] i, input bit rd);
        reset = r; rv = v; pc = p; instr = i; rdy = rd;
        model_edge();
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic idle(input bit rd);
        step(1'b0, 1'b0, 32'h0, 32'h0, rd);
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [31:0] ins;
        logic [2:0]  cls;
        bit          bad;
    } vec_t;

    vec_t vt [22];

    logic [5:0] rop [16] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                             6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h3f};
    logic [5:0] rfn [7]  = '{6'h20, 6'h21, 6'h23, 6'h25, 6'h30, 6'h10, 6'h3f};

    initial begin
        logic [31:0] add_i;
        logic [31:0] lw_i;
        int          n;

        vt[0]  = '{mk(6'h00, 6'h20), 3'd0, 1'b0};
        vt[1]  = '{mk(6'h00, 6'h21), 3'd0, 1'b0};
        vt[2]  = '{mk(6'h00, 6'h23), 3'd0, 1'b0};
        vt[3]  = '{mk(6'h00, 6'h25), 3'd0, 1'b0};
        vt[4]  = '{mk(6'h00, 6'h30), 3'd0, 1'b0};
        vt[5]  = '{mk(6'h00, 6'h10), 3'd0, 1'b1};
        vt[6]  = '{mk(6'h08, 6'h00), 3'd1, 1'b0};
        vt[7]  = '{mk(6'h0a, 6'h11), 3'd1, 1'b0};
        vt[8]  = '{mk(6'h0c, 6'h00), 3'd1, 1'b0};
        vt[9]  = '{mk(6'h0d, 6'h00), 3'd1, 1'b0};
        vt[10] = '{mk(6'h23, 6'h00), 3'd2, 1'b0};
        vt[11] = '{mk(6'h2b, 6'h00), 3'd3, 1'b0};
        vt[12] = '{mk(6'h04, 6'h00), 3'd4, 1'b0};
        vt[13] = '{mk(6'h05, 6'h00), 3'd4, 1'b0};
        vt[14] = '{mk(6'h06, 6'h00), 3'd5, 1'b0};
        vt[15] = '{mk(6'h07, 6'h00), 3'd5, 1'b0};
        vt[16] = '{mk(6'h0f, 6'h00), 3'd6, 1'b0};
        vt[17] = '{mk(6'h02, 6'h00), 3'd7, 1'b0};
        vt[18] = '{mk(6'h03, 6'h00), 3'd7, 1'b0};
        vt[19] = '{mk(6'h3f, 6'h20), 3'd0, 1'b1};
        vt[20] = '{mk(6'h01, 6'h00), 3'd0, 1'b1};
        vt[21] = '{mk(6'h09, 6'h00), 3'd0, 1'b1};

        add_i = mk(6'h00, 6'h20);
        lw_i  = mk(6'h23, 6'h00);

        // Reset state
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset trace_valid", 128'(if0.trace_valid), 128'(0));
        chk("reset class_counts", cc0, 128'(0));
        chk("reset cycle_count", 128'(cyc0), 128'(0));
        chk("reset done", 128'(dn), 128'(0));

        // Decode table: one retire per vector from reset
        for (int t = 0; t < 22; t++) begin
            step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            step(1'b0, 1'b1, 32'h40, vt[t].ins, 1'b0);
            chk($sformatf("vec%0d class", t), 128'(if0.trace_data[66:64]), 128'(vt[t].cls));
            chk($sformatf("vec%0d illegal", t), 128'(ill[0]), 128'(vt[t].bad));
            chk($sformatf("vec%0d counter", t), 128'(cc0[vt[t].cls*16 +: 16]), 128'(vt[t].bad ? 0 : 1));
        end

        // add then lw: one-cycle latency, two entries, two counters
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, add_i, 1'b0);
        chk("t1 valid after 1", 128'(if0.trace_valid), 128'(1));
        chk("t1 head0", 128'(if0.trace_data), 128'({3'd0, 32'h0, add_i}));
        step(1'b0, 1'b1, 32'h4, lw_i, 1'b0);
        chk("t1 cnt0", 128'(cc0[15:0]), 128'(1));
        chk("t1 cnt2", 128'(cc0[47:32]), 128'(1));
        idle(1'b1);
        chk("t1 head1", 128'(if0.trace_data), 128'({3'd2, 32'h4, lw_i}));

        // Six retires into DEPTH=4 FIFOs with no consumer
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 32'(k * 4), add_i, 1'b0);
        chk("t2 drop ow0", 128'(drp1), 128'(2));
        chk("t2 drop ow1", 128'(drp2), 128'(2));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2 ow0 pc%0d", k), 128'(if1.trace_data[63:32]), 128'(k * 4));
            chk($sformatf("t2 ow1 pc%0d", k), 128'(if2.trace_data[63:32]), 128'(8 + k * 4));
            idle(1'b1);
        end

        // Full FIFO: push and pop in the same cycle
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'(k * 4), add_i, 1'b0);
        step(1'b0, 1'b1, 32'h10, add_i, 1'b1);
        chk("t3 drop", 128'(drp1), 128'(0));
        chk("t3 head", 128'(if1.trace_data[63:32]), 128'(4));
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (if1.trace_valid) begin
                n++;
                idle(1'b1);
            end
        end
        chk("t3 occupancy", 128'(n), 128'(4));

        // Halt with three entries queued
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'(k * 4), add_i, 1'b0);
        step(1'b0, 1'b1, 32'hffff, lw_i, 1'b0);
        chk("t4 halted", 128'(hlt[0]), 128'(1));
        chk("t4 cycles", 128'(cyc0), 128'(4));
        step(1'b0, 1'b1, 32'h80, lw_i, 1'b0);
        step(1'b0, 1'b1, 32'h84, lw_i, 1'b0);
        chk("t4 frozen cycles", 128'(cyc0), 128'(4));
        chk("t4 no load counted", 128'(cc0[47:32]), 128'(0));
        for (int k = 0; k < 3; k++) idle(1'b1);
        chk("t4 done early", 128'(dn[0]), 128'(0));
        idle(1'b1);
        chk("t4 done", 128'(dn[0]), 128'(1));

        // Counter saturation on the 4-bit instances
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 17; k++) step(1'b0, 1'b1, 32'(k * 4), lw_i, 1'b1);
        chk("t5 load sat", 128'(cc1[11:8]), 128'(15));
        chk("t5 cycle sat", 128'(cyc1), 128'(15));

        // Reset while draining
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, add_i, 1'b0);
        step(1'b0, 1'b1, 32'h4, add_i, 1'b0);
        step(1'b0, 1'b1, 32'hffff, add_i, 1'b0);
        idle(1'b0);
        chk("t6 draining", 128'(hlt[0]), 128'(1));
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6 valid", 128'(if0.trace_valid), 128'(0));
        chk("t6 halted", 128'(hlt[0]), 128'(0));
        chk("t6 counts", cc0, 128'(0));
        step(1'b0, 1'b1, 32'h8, add_i, 1'b0);
        chk("t6 run again", 128'(if0.trace_valid), 128'(1));

        // Randomized traffic against the model
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] ri;
            logic [31:0] rp;
            bit          rr;
            ri = mk(rop[$urandom_range(0, 15)], rfn[$urandom_range(0, 6)]);
            ri[25:10] = 16'($urandom);
            rp = ($urandom_range(0, 199) == 0) ? 32'hffff : {22'h0, 8'($urandom), 2'b00};
            rr = ($urandom_range(0, 249) == 0);
            step(rr, ($urandom_range(0, 3) != 0), rp, ri, ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
